fifo_rd_stream_adapter: RTL and testbench
=========================================

Name: fifo_rd_stream_adapter

Overview:
Read-side consumer of the asynchronous FIFO, running entirely in the R_CLK domain. Drives the FIFO's R_EN from EMPTY, captures O_DATA, and presents it downstream as a valid/ready stream. A small registered skid buffer absorbs the FIFO's 1-cycle read latency, so full throughput (1 word/cycle) is sustained with no combinational path from M_READY to R_EN.

Parameters:
data_width, 9, word width; matches FIFO data_width (bit 8 = parity bit when checking is enabled)
BUF_DEPTH, 3, skid buffer entries; legal range 2..8; 3 is the minimum for full throughput
CNT_WIDTH, 16, width of the delivered-word counter

Ports:
R_CLK  input  1  read-domain clock
RRST_n  input  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronous to R_CLK (synchronised upstream)
EMPTY  input  1  FIFO empty flag, R_CLK domain
O_DATA  input  data_width  FIFO read data; valid the R_CLK cycle after a cycle with R_EN=1 and EMPTY=0
R_EN  output  1  FIFO read request
M_DATA  output  data_width  stream data (head of skid buffer)
M_VALID  output  1  stream data valid
M_READY  input  1  downstream accept
RD_COUNT  output  CNT_WIDTH  words delivered downstream (count of M_VALID&&M_READY), wraps
PAR_ERR  output  1  sticky parity error flag (see Optional Feature)

Behaviour:
- Reset (RRST_n=0, async): R_EN=0, M_VALID=0, M_DATA=0, RD_COUNT=0, PAR_ERR=0; occupancy occ=0, inflight=0, head/tail pointers=0; skid buffer contents don't-care.
- State: occ (0..BUF_DEPTH) = entries held; inflight (1 bit) = R_EN was issued with EMPTY=0 last cycle.
- R_EN = !EMPTY && (occ + inflight) < BUF_DEPTH. Combinational from registered state and EMPTY only; never depends on M_READY.
- Read issue: a cycle with R_EN=1 (so EMPTY=0) sets inflight=1 next cycle; otherwise inflight=0.
- Capture: when inflight=1, O_DATA is written at the tail on that R_CLK edge; tail advances modulo BUF_DEPTH.
- Pop: M_VALID = (occ != 0); M_DATA = entry at head. M_VALID&&M_READY advances head modulo BUF_DEPTH and increments RD_COUNT (wraps 2^CNT_WIDTH-1 -> 0).
- Simultaneous capture and pop: occ unchanged; both pointers advance. With occ=1, the captured word must not overwrite the head being popped.
- Latency: EMPTY falling with occ=0 -> R_EN same cycle -> M_VALID 2 cycles after the cycle EMPTY went low.
- Stream rules: once M_VALID=1, M_DATA is held stable until accepted. M_VALID never drops without a handshake except on reset. Words are delivered in FIFO order with no loss or duplication.
- Overflow impossible by construction: occ + inflight <= BUF_DEPTH at all times. An assertion checks occ never exceeds BUF_DEPTH.
- EMPTY asserting while inflight=1: the in-flight word is still captured; no further R_EN.
- Reset mid-transfer: buffered and in-flight words are discarded. The FIFO read pointer is reset by the same RRST_n, so no state is inconsistent.

Optional Feature:
Macro RD_PARITY_CHK_EN.
- Defined: each captured word is checked for even parity over all data_width bits. Any odd-parity word sets PAR_ERR=1 on the capture edge; it stays set until reset. The word is still delivered unchanged.
- Undefined: PAR_ERR is tied 0 and no checker logic is generated; the port is still present.

Test Plan:
- Reset, then EMPTY=1 for 10 cycles -> R_EN=0, M_VALID=0, RD_COUNT=0 throughout.
- FIFO model holds 0x001..0x008, M_READY=1 constantly -> R_EN high 8 consecutive cycles; M_DATA 0x001..0x008 on 8 consecutive cycles starting 2 cycles after first R_EN; RD_COUNT=8.
- FIFO holds 6 words, M_READY=0 -> R_EN issues exactly 3 reads then stays 0; M_VALID=1 with M_DATA=word0 held stable. Raise M_READY -> all 6 words delivered in order.
- M_READY toggling 1010..., 20 words -> no drop or duplication, order preserved, R_EN never high when occ+inflight=3, RD_COUNT=20.
- RRST_n pulsed low for 1 cycle with occ=2, inflight=1 -> M_VALID=0 and R_EN=0 immediately; RD_COUNT=0; normal operation after release.
- RD_PARITY_CHK_EN defined, word 0x001 (odd parity) injected -> PAR_ERR=1 the cycle after capture, stays 1 through later good words, clears only on reset. Undefined build -> PAR_ERR=0.

Source files
------------

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side FIFO consumer: issues R_EN from EMPTY and a registered skid buffer, presents a valid/ready stream.
// Optional even-parity checking of captured words is enabled by defining RD_PARITY_CHK_EN.
module fifo_rd_stream_adapter #(
  parameter int data_width = 9,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  R_CLK,
  input  logic                  RRST_n,
  input  logic                  EMPTY,
  input  logic [data_width-1:0] O_DATA,
  output logic                  R_EN,
  output logic [data_width-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [CNT_WIDTH-1:0]  RD_COUNT,
  output logic                  PAR_ERR
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [OCC_W:0]   DEPTH_EXT = (OCC_W + 1)'(BUF_DEPTH);

  logic [data_width-1:0] buf_q [BUF_DEPTH];
  logic [data_width-1:0] buf_d [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [OCC_W:0]        pending;
  logic                  capture;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign M_VALID  = (occ_q != '0);
  assign M_DATA   = buf_q[head_q];
  assign RD_COUNT = cnt_q;

  // Reads are only issued when every held and in-flight word already has a slot reserved
  always_comb begin
    pending    = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
    R_EN       = !EMPTY && (pending < DEPTH_EXT);
    capture    = inflight_q;
    pop        = M_VALID && M_READY;
    inflight_d = R_EN;
    buf_d      = buf_q;
    if (capture) begin
      buf_d[tail_q] = O_DATA;
    end
    tail_d = capture ? ptr_inc(tail_q) : tail_q;
    head_d = pop ? ptr_inc(head_q) : head_q;
    occ_d  = occ_q;
    if (capture && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!capture && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
    cnt_d = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge R_CLK or negedge RRST_n) begin
    if (!RRST_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      buf_q      <= buf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef RD_PARITY_CHK_EN
  logic par_err_q, par_err_d;

  // Sticky flag: any odd-parity word seen on a capture edge latches until reset
  always_comb begin
    par_err_d = par_err_q | (capture & (^O_DATA));
  end

  always_ff @(posedge R_CLK or negedge RRST_n) begin
    if (!RRST_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign PAR_ERR = par_err_q;
`else
  assign PAR_ERR = 1'b0;
`endif

  occ_bound_a: assert property (@(posedge R_CLK) disable iff (!RRST_n)
    ({1'b0, occ_q} <= DEPTH_EXT));

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench for fifo_rd_stream_adapter: a FIFO model feeds words, a monitor checks the stream in order.
module tb_fifo_rd_stream_adapter;

  localparam int DW    = 9;
  localparam int DEPTH = 3;
  localparam int CW    = 16;
`ifdef RD_PARITY_CHK_EN
  localparam logic EXP_PAR = 1'b1;
`else
  localparam logic EXP_PAR = 1'b0;
`endif

  logic          R_CLK   = 1'b0;
  logic          RRST_n  = 1'b0;
  logic          EMPTY   = 1'b1;
  logic [DW-1:0] O_DATA  = '0;
  logic          M_READY = 1'b0;
  logic          R_EN;
  logic [DW-1:0] M_DATA;
  logic          M_VALID;
  logic [CW-1:0] RD_COUNT;
  logic          PAR_ERR;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q [$];

  int            tb_pend    = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  int ren_cnt = 0, ren_first = 0, ren_last = 0;
  int hs_cnt  = 0, hs_first  = 0, hs_last  = 0;

  fifo_rd_stream_adapter #(
    .data_width(DW),
    .BUF_DEPTH (DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .R_CLK   (R_CLK),
    .RRST_n  (RRST_n),
    .EMPTY   (EMPTY),
    .O_DATA  (O_DATA),
    .R_EN    (R_EN),
    .M_DATA  (M_DATA),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .RD_COUNT(RD_COUNT),
    .PAR_ERR (PAR_ERR)
  );

  always #5 R_CLK = ~R_CLK;

  always @(posedge R_CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic stepCycle();
    @(posedge R_CLK);
    #2;
  endtask

  task automatic clearStats();
    ren_cnt = 0; ren_first = 0; ren_last = 0;
    hs_cnt  = 0; hs_first  = 0; hs_last  = 0;
  endtask

  task automatic doReset();
    RRST_n  = 1'b0;
    EMPTY   = 1'b1;
    M_READY = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    stepCycle();
    stepCycle();
    RRST_n = 1'b1;
    clearStats();
    stepCycle();
  endtask

  task automatic waitDrain(input string name, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || M_VALID) && n < bound) begin
      stepCycle();
      n++;
    end
    checkOutput(name, exp_q.size() + int'(M_VALID), 0);
  endtask

  // FIFO model: a read granted in one cycle returns its word just after the next edge
  initial begin : fifoModel
    logic fire;
    forever begin
      @(negedge R_CLK);
      fire = R_EN && !EMPTY;
      @(posedge R_CLK);
      #1;
      if (fire && fifo_q.size() > 0) O_DATA = fifo_q.pop_front();
      EMPTY = (fifo_q.size() == 0);
    end
  end

  // Monitor: checks order, hold-while-stalled and that reads never exceed buffer room
  initial begin : monitor
    logic fire, hs;
    forever begin
      @(negedge R_CLK);
      if (!RRST_n) begin
        tb_pend    = 0;
        prev_stall = 1'b0;
      end else begin
        fire = R_EN && !EMPTY;
        hs   = M_VALID && M_READY;
        if (R_EN) checkOutput("ren_room", 32'(tb_pend < DEPTH), 1);
        if (prev_stall) begin
          checkOutput("valid_hold", M_VALID, 1);
          checkOutput("data_hold", M_DATA, prev_data);
        end
        if (hs) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL extra_word: got 0x%0h, expected no word", M_DATA);
          end else begin
            checkOutput("stream_data", M_DATA, exp_q.pop_front());
          end
          if (hs_cnt == 0) hs_first = cyc;
          hs_last = cyc;
          hs_cnt++;
        end
        if (fire) begin
          if (ren_cnt == 0) ren_first = cyc;
          ren_last = cyc;
          ren_cnt++;
        end
        tb_pend    = tb_pend + (fire ? 1 : 0) - (hs ? 1 : 0);
        prev_stall = M_VALID && !M_READY;
        prev_data  = M_DATA;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    // Idle after reset
    doReset();
    checkOutput("rst_m_valid", M_VALID, 0);
    checkOutput("rst_m_data", M_DATA, 0);
    checkOutput("rst_par_err", PAR_ERR, 0);
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput("idle_r_en", R_EN, 0);
      checkOutput("idle_m_valid", M_VALID, 0);
      checkOutput("idle_rd_count", RD_COUNT, 0);
    end

    // Full throughput, 8 words
    doReset();
    M_READY = 1'b1;
    for (int i = 1; i <= 8; i++) applyStimulus(DW'(i));
    waitDrain("thru_drain", 60);
    checkOutput("thru_ren_cnt", ren_cnt, 8);
    checkOutput("thru_ren_span", ren_last - ren_first, 7);
    checkOutput("thru_latency", hs_first - ren_first, 2);
    checkOutput("thru_hs_cnt", hs_cnt, 8);
    checkOutput("thru_hs_span", hs_last - hs_first, 7);
    checkOutput("thru_rd_count", RD_COUNT, 8);

    // Backpressure: only 3 reads while stalled
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(9'h0A0 + DW'(i));
    repeat (10) stepCycle();
    checkOutput("stall_ren_cnt", ren_cnt, 3);
    checkOutput("stall_r_en", R_EN, 0);
    checkOutput("stall_m_valid", M_VALID, 1);
    checkOutput("stall_m_data", M_DATA, 9'h0A0);
    M_READY = 1'b1;
    waitDrain("stall_drain", 60);
    checkOutput("stall_rd_count", RD_COUNT, 6);
    checkOutput("stall_hs_cnt", hs_cnt, 6);

    // Toggling ready, 20 words
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(9'h100 + DW'(i * 5));
    M_READY = 1'b1;
    for (int n = 0; n < 200 && (exp_q.size() != 0 || M_VALID); n++) begin
      stepCycle();
      M_READY = ~M_READY;
    end
    checkOutput("toggle_left", exp_q.size(), 0);
    checkOutput("toggle_rd_count", RD_COUNT, 20);
    checkOutput("toggle_hs_cnt", hs_cnt, 20);

    // Reset pulse with two words held and one in flight
    doReset();
    M_READY = 1'b1;
    applyStimulus(9'h011);
    applyStimulus(9'h022);
    waitDrain("pre_rst_drain", 40);
    checkOutput("pre_rst_rd_count", RD_COUNT, 2);
    M_READY = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(9'h030 + DW'(i));
    repeat (4) stepCycle();
    checkOutput("pre_rst_m_valid", M_VALID, 1);
    checkOutput("pre_rst_r_en", R_EN, 0);
    checkOutput("pre_rst_m_data", M_DATA, 9'h030);
    RRST_n = 1'b0;
    EMPTY  = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    #1;
    checkOutput("mid_rst_m_valid", M_VALID, 0);
    checkOutput("mid_rst_r_en", R_EN, 0);
    checkOutput("mid_rst_rd_count", RD_COUNT, 0);
    checkOutput("mid_rst_m_data", M_DATA, 0);
    stepCycle();
    RRST_n = 1'b1;
    clearStats();
    stepCycle();
    M_READY = 1'b1;
    applyStimulus(9'h041);
    applyStimulus(9'h042);
    applyStimulus(9'h043);
    waitDrain("post_rst_drain", 40);
    checkOutput("post_rst_rd_count", RD_COUNT, 3);

    // Parity flag: 0x003 even, 0x001 odd, then more even words
    doReset();
    checkOutput("par_after_rst", PAR_ERR, 0);
    M_READY = 1'b1;
    applyStimulus(9'h003);
    applyStimulus(9'h001);
    applyStimulus(9'h005);
    applyStimulus(9'h006);
    repeat (3) stepCycle();
    checkOutput("par_good_word", PAR_ERR, 0);
    stepCycle();
    checkOutput("par_bad_word", PAR_ERR, EXP_PAR);
    waitDrain("par_drain", 40);
    checkOutput("par_sticky", PAR_ERR, EXP_PAR);
    checkOutput("par_rd_count", RD_COUNT, 4);
    doReset();
    checkOutput("par_cleared", PAR_ERR, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
